// File: rtl/ir_frame_tx_if.sv
// Command handshake between the control logic and ir_frame_tx.
// The rpt field exists only when IR_FRAME_TX_REPEAT_EN is defined.
interface ir_frame_tx_if #(
    parameter int DATA_W = 32
);
    localparam int LEN_W = $clog2(DATA_W + 1);

    logic [DATA_W-1:0] cmd;
    logic [LEN_W-1:0]  len;
    logic              valid;
    logic              ready;
`ifdef IR_FRAME_TX_REPEAT_EN
    logic [3:0]        rpt;

    modport master (output cmd, output len, output valid, output rpt, input ready);
    modport slave  (input cmd, input len, input valid, input rpt, output ready);
`else
    modport master (output cmd, output len, output valid, input ready);
    modport slave  (input cmd, input len, input valid, output ready);
`endif
endinterface

// File: rtl/ir_frame_tx.sv
// Pulse-distance IR frame transmitter: header mark/space, 1..DATA_W payload bits, trailer mark.
// Optional macro IR_FRAME_TX_REPEAT_EN adds frame repeats separated by a silent gap.
module ir_frame_tx #(
    parameter int CLK_FREQ        = 25_000_000,
    parameter int CARRIER_FREQ    = 36_000,
    parameter int DATA_W          = 32,
    parameter int UNIT_TICKS      = 10416,
    parameter int MARK_UNITS      = 1,
    parameter int ZERO_UNITS      = 1,
    parameter int ONE_UNITS       = 3,
    parameter int HDR_MARK_TICKS  = 109368,
    parameter int HDR_SPACE_TICKS = 109368,
    parameter int LSB_FIRST       = 1,
    parameter int GAP_TICKS       = 500000
) (
    input  logic               clk,
    input  logic               rst,
    ir_frame_tx_if.slave       bus,
    input  logic               abort,
    output logic               done,
    output logic               busy,
    output logic               ir_output
);
    localparam int CARRIER_DIV = CLK_FREQ / (2 * CARRIER_FREQ);
    localparam int MARK_T = MARK_UNITS * UNIT_TICKS;
    localparam int ZERO_T = ZERO_UNITS * UNIT_TICKS;
    localparam int ONE_T  = ONE_UNITS * UNIT_TICKS;

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    localparam int MAX_SEG = max2(max2(max2(HDR_MARK_TICKS, HDR_SPACE_TICKS), max2(MARK_T, ZERO_T)),
                                  max2(ONE_T, GAP_TICKS));
    localparam int CW = $clog2(MAX_SEG + 1);
    localparam int DW = (CARRIER_DIV > 1) ? $clog2(CARRIER_DIV) : 1;
    localparam int BW = $clog2(DATA_W + 1);

    // Segment lengths stored as last-tick index so the end test is a plain compare
    localparam logic [CW-1:0] LAST_HM   = CW'(HDR_MARK_TICKS - 1);
    localparam logic [CW-1:0] LAST_HS   = CW'(HDR_SPACE_TICKS - 1);
    localparam logic [CW-1:0] LAST_MK   = CW'(MARK_T - 1);
    localparam logic [CW-1:0] LAST_ZERO = CW'(ZERO_T - 1);
    localparam logic [CW-1:0] LAST_ONE  = CW'(ONE_T - 1);
`ifdef IR_FRAME_TX_REPEAT_EN
    localparam logic [CW-1:0] LAST_GAP  = CW'(GAP_TICKS - 1);
`endif
    localparam logic [DW-1:0] CAR_LAST  = DW'(CARRIER_DIV - 1);

    localparam logic [2:0] IDLE       = 3'd0;
    localparam logic [2:0] HDR_MARK   = 3'd1;
    localparam logic [2:0] HDR_SPACE  = 3'd2;
    localparam logic [2:0] BIT_MARK   = 3'd3;
    localparam logic [2:0] BIT_SPACE  = 3'd4;
    localparam logic [2:0] TRAIL_MARK = 3'd5;
`ifdef IR_FRAME_TX_REPEAT_EN
    localparam logic [2:0] GAP        = 3'd6;
`endif

    logic [2:0]        state_q, state_d;
    logic [CW-1:0]     seg_q, seg_d;
    logic [DW-1:0]     car_q, car_d;
    logic              ir_q, ir_d;
    logic              done_q, done_d;
    logic [DATA_W-1:0] cmd_q, cmd_d;
    logic [BW-1:0]     len_q, len_d;
    logic [DATA_W-1:0] sh_q, sh_d;
    logic [BW-1:0]     bits_q, bits_d;
`ifdef IR_FRAME_TX_REPEAT_EN
    logic [3:0]        rpt_q, rpt_d;
    logic [3:0]        rep_q, rep_d;
`endif

    logic              cur_bit;
    logic [CW-1:0]     seg_last;
    logic              seg_end;
    logic [BW-1:0]     eff_len;
    logic              seg_start;

    // MSB-first payloads are left-aligned so the active bit is always the top bit
    function automatic logic [DATA_W-1:0] load_sh(input logic [DATA_W-1:0] c, input logic [BW-1:0] l);
        if (LSB_FIRST != 0) return c;
        return c << (DATA_W - int'(l));
    endfunction

    always_comb begin
        cur_bit = (LSB_FIRST != 0) ? sh_q[0] : sh_q[DATA_W-1];
        eff_len = (bus.len == '0 || bus.len > BW'(DATA_W)) ? BW'(DATA_W) : bus.len;

        seg_last = LAST_MK;
        case (state_q)
            HDR_MARK:  seg_last = LAST_HM;
            HDR_SPACE: seg_last = LAST_HS;
            BIT_SPACE: seg_last = cur_bit ? LAST_ONE : LAST_ZERO;
`ifdef IR_FRAME_TX_REPEAT_EN
            GAP:       seg_last = LAST_GAP;
`endif
            default:   seg_last = LAST_MK;
        endcase
        seg_end = (seg_q == seg_last);

        state_d = state_q;
        cmd_d   = cmd_q;
        len_d   = len_q;
        sh_d    = sh_q;
        bits_d  = bits_q;
        done_d  = 1'b0;
`ifdef IR_FRAME_TX_REPEAT_EN
        rpt_d   = rpt_q;
        rep_d   = rep_q;
`endif

        case (state_q)
            IDLE: begin
                if (bus.valid) begin
                    cmd_d   = bus.cmd;
                    len_d   = eff_len;
                    sh_d    = load_sh(bus.cmd, eff_len);
                    bits_d  = eff_len;
`ifdef IR_FRAME_TX_REPEAT_EN
                    rpt_d   = bus.rpt;
                    rep_d   = 4'd0;
`endif
                    state_d = HDR_MARK;
                end
            end
            HDR_MARK:  if (seg_end) state_d = HDR_SPACE;
            HDR_SPACE: if (seg_end) state_d = BIT_MARK;
            BIT_MARK:  if (seg_end) state_d = BIT_SPACE;
            BIT_SPACE: begin
                if (seg_end) begin
                    sh_d    = (LSB_FIRST != 0) ? (sh_q >> 1) : (sh_q << 1);
                    bits_d  = bits_q - BW'(1);
                    state_d = (bits_q == BW'(1)) ? TRAIL_MARK : BIT_MARK;
                end
            end
            TRAIL_MARK: begin
                if (seg_end) begin
`ifdef IR_FRAME_TX_REPEAT_EN
                    if (rep_q < rpt_q) begin
                        rep_d   = rep_q + 4'd1;
                        state_d = GAP;
                    end else begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
`else
                    state_d = IDLE;
                    done_d  = 1'b1;
`endif
                end
            end
`ifdef IR_FRAME_TX_REPEAT_EN
            GAP: begin
                if (seg_end) begin
                    sh_d    = load_sh(cmd_q, len_q);
                    bits_d  = len_q;
                    state_d = HDR_MARK;
                end
            end
`endif
            default: state_d = IDLE;
        endcase

        // Abort overrides everything, including a completion on the same edge
        if (abort && state_q != IDLE) begin
            state_d = IDLE;
            done_d  = 1'b0;
        end

        // Every transition changes state, so a state change marks a segment start
        seg_start = (state_d != state_q);
        seg_d     = (seg_start || state_d == IDLE) ? '0 : seg_q + CW'(1);

        car_d = '0;
        ir_d  = 1'b0;
        if (state_d == HDR_MARK || state_d == BIT_MARK || state_d == TRAIL_MARK) begin
            if (seg_start) begin
                car_d = '0;
                ir_d  = 1'b1;
            end else if (car_q == CAR_LAST) begin
                car_d = '0;
                ir_d  = ~ir_q;
            end else begin
                car_d = car_q + DW'(1);
                ir_d  = ir_q;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            seg_q   <= '0;
            car_q   <= '0;
            ir_q    <= 1'b0;
            done_q  <= 1'b0;
            cmd_q   <= '0;
            len_q   <= '0;
            sh_q    <= '0;
            bits_q  <= '0;
`ifdef IR_FRAME_TX_REPEAT_EN
            rpt_q   <= '0;
            rep_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            seg_q   <= seg_d;
            car_q   <= car_d;
            ir_q    <= ir_d;
            done_q  <= done_d;
            cmd_q   <= cmd_d;
            len_q   <= len_d;
            sh_q    <= sh_d;
            bits_q  <= bits_d;
`ifdef IR_FRAME_TX_REPEAT_EN
            rpt_q   <= rpt_d;
            rep_q   <= rep_d;
`endif
        end
    end

    assign bus.ready = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign done      = done_q;
    assign ir_output = ir_q;
endmodule

// File: tb/tb_ir_frame_tx.sv
// Bench for ir_frame_tx: LSB-first and MSB-first instances checked cycle by cycle
// against a waveform model built from the segment rules.
module tb_ir_frame_tx;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic abort_l, abort_m;
    logic done_l, done_m, busy_l, busy_m, ir_l, ir_m;

    ir_frame_tx_if #(.DATA_W(8)) bus_l ();
    ir_frame_tx_if #(.DATA_W(8)) bus_m ();

    localparam int HM = 80, HS = 40, UNIT = 20, DIV = 5, GAPT = 50;

    ir_frame_tx #(
        .CLK_FREQ(1000), .CARRIER_FREQ(100), .DATA_W(8), .UNIT_TICKS(UNIT),
        .MARK_UNITS(1), .ZERO_UNITS(1), .ONE_UNITS(3),
        .HDR_MARK_TICKS(HM), .HDR_SPACE_TICKS(HS), .LSB_FIRST(1), .GAP_TICKS(GAPT)
    ) dut_l (
        .clk(clk), .rst(rst), .bus(bus_l), .abort(abort_l),
        .done(done_l), .busy(busy_l), .ir_output(ir_l)
    );

    ir_frame_tx #(
        .CLK_FREQ(1000), .CARRIER_FREQ(100), .DATA_W(8), .UNIT_TICKS(UNIT),
        .MARK_UNITS(1), .ZERO_UNITS(1), .ONE_UNITS(3),
        .HDR_MARK_TICKS(HM), .HDR_SPACE_TICKS(HS), .LSB_FIRST(0), .GAP_TICKS(GAPT)
    ) dut_m (
        .clk(clk), .rst(rst), .bus(bus_m), .abort(abort_m),
        .done(done_m), .busy(busy_m), .ir_output(ir_m)
    );

    int n_cmp = 0;
    int n_bad = 0;
    bit exp_q[$];

    task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed={busy,ready,done,ir}=%b expected=%b", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] obs(input bit msb);
        return msb ? {busy_m, bus_m.ready, done_m, ir_m} : {busy_l, bus_l.ready, done_l, ir_l};
    endfunction

    task automatic drive(input bit msb, input logic v, input logic [7:0] c, input logic [3:0] l,
                         input int rpt, input logic a);
        if (msb) begin
            bus_m.valid = v; bus_m.cmd = c; bus_m.len = l; abort_m = a;
`ifdef IR_FRAME_TX_REPEAT_EN
            bus_m.rpt = 4'(rpt);
`endif
        end else begin
            bus_l.valid = v; bus_l.cmd = c; bus_l.len = l; abort_l = a;
`ifdef IR_FRAME_TX_REPEAT_EN
            bus_l.rpt = 4'(rpt);
`endif
        end
    endtask

    function automatic void push_mark(input int n);
        for (int k = 0; k < n; k++) exp_q.push_back((k % (2 * DIV)) < DIV);
    endfunction

    function automatic void push_space(input int n);
        for (int k = 0; k < n; k++) exp_q.push_back(1'b0);
    endfunction

    // Expected ir_output for every busy cycle of the whole transaction
    function automatic void build(input bit msb, input logic [7:0] c, input logic [3:0] l, input int rpt);
        int n;
        bit b;
        exp_q.delete();
        n = (l == 0 || l > 8) ? 8 : int'(l);
        for (int r = 0; r <= rpt; r++) begin
            if (r > 0) push_space(GAPT);
            push_mark(HM);
            push_space(HS);
            for (int i = 0; i < n; i++) begin
                b = msb ? c[n - 1 - i] : c[i];
                push_mark(UNIT);
                push_space(b ? 3 * UNIT : UNIT);
            end
            push_mark(UNIT);
        end
    endfunction

    task automatic run_frame(input bit msb, input logic [7:0] c, input logic [3:0] l, input int rpt,
                             input int abort_at, input bit hold);
        int ab;
        build(msb, c, l, rpt);
        ab = (abort_at >= 0) ? abort_at % exp_q.size() : -1;
        $display("frame msb=%0d cmd=%h len=%0d rpt=%0d cycles=%0d abort_at=%0d hold=%0d",
                 msb, c, l, rpt, exp_q.size(), ab, hold);
        @(negedge clk);
        drive(msb, 1'b1, c, l, rpt, 1'b0);
        @(negedge clk);
        if (!hold) drive(msb, 1'b0, c, l, rpt, 1'b0);
        for (int k = 0; k < exp_q.size(); k++) begin
            if (k > 0) @(negedge clk);
            check($sformatf("frame_k%0d", k), obs(msb), {3'b100, exp_q[k]});
            if (k == ab) begin
                drive(msb, 1'b0, c, l, rpt, 1'b1);
                @(negedge clk);
                drive(msb, 1'b0, c, l, rpt, 1'b0);
                check("abort_idle", obs(msb), 4'b0100);
                return;
            end
        end
        @(negedge clk);
        check("done_pulse", obs(msb), 4'b0110);
        if (hold) begin
            @(negedge clk);
            check("b2b_accept", obs(msb), 4'b1001);
            drive(msb, 1'b0, c, l, rpt, 1'b1);
            @(negedge clk);
            drive(msb, 1'b0, c, l, rpt, 1'b0);
            check("b2b_abort", obs(msb), 4'b0100);
        end else begin
            @(negedge clk);
            check("done_clear", obs(msb), 4'b0100);
        end
    endtask

    initial begin
        int rpt;
        rst = 1'b1;
        drive(1'b0, 1'b0, 8'h00, 4'd0, 0, 1'b0);
        drive(1'b1, 1'b0, 8'h00, 4'd0, 0, 1'b0);

        // Reset state, then 100 idle cycles
        repeat (3) @(negedge clk);
        check("reset_l", obs(1'b0), 4'b0100);
        check("reset_m", obs(1'b1), 4'b0100);
        rst = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            check("idle_l", obs(1'b0), 4'b0100);
            check("idle_m", obs(1'b1), 4'b0100);
        end
        $display("reset/idle done");

        // Directed frames
        run_frame(1'b0, 8'h05, 4'd4, 0, -1, 1'b0);
        run_frame(1'b1, 8'h05, 4'd4, 0, -1, 1'b0);
        run_frame(1'b0, 8'hff, 4'd0, 0, -1, 1'b0);
        run_frame(1'b1, 8'h81, 4'd12, 0, -1, 1'b0);
        run_frame(1'b0, 8'h05, 4'd4, 0, 190, 1'b0);
        run_frame(1'b0, 8'h05, 4'd4, 0, -1, 1'b0);
        run_frame(1'b1, 8'h03, 4'd2, 0, 379 - 80 - 80, 1'b0);
        run_frame(1'b0, 8'h0a, 4'd1, 0, 159, 1'b0);
        run_frame(1'b1, 8'h5a, 4'd8, 0, -1, 1'b1);
`ifdef IR_FRAME_TX_REPEAT_EN
        run_frame(1'b0, 8'h05, 4'd4, 2, -1, 1'b0);
        run_frame(1'b1, 8'h05, 4'd4, 1, 420, 1'b0);
`endif

        // Abort while idle is ignored
        @(negedge clk);
        drive(1'b0, 1'b0, 8'h00, 4'd0, 0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("abort_in_idle", obs(1'b0), 4'b0100);
        end
        drive(1'b0, 1'b0, 8'h00, 4'd0, 0, 1'b0);

        // Asynchronous reset in mid-frame takes effect before the next edge
        @(negedge clk);
        drive(1'b0, 1'b1, 8'h33, 4'd6, 0, 1'b0);
        repeat (30) @(negedge clk);
        drive(1'b0, 1'b0, 8'h33, 4'd6, 0, 1'b0);
        check("pre_rst_busy", obs(1'b0) & 4'b1100, 4'b1000);
        #1 rst = 1'b1;
        #1 check("async_rst", obs(1'b0), 4'b0100);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("post_rst", obs(1'b0), 4'b0100);
        $display("abort/reset directed done");

        // Randomized frames
        for (int t = 0; t < 24; t++) begin
`ifdef IR_FRAME_TX_REPEAT_EN
            rpt = int'($urandom_range(0, 2));
`else
            rpt = 0;
`endif
            run_frame(1'($urandom_range(0, 1)), 8'($urandom), 4'($urandom_range(0, 15)), rpt,
                      ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 5000)) : -1,
                      ($urandom_range(0, 5) == 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
